hand_deal_ctrl: RTL and testbench

HAND_DEAL_CTRL -- requirements
Module: hand_deal_ctrl

---
 rtl/hand_deal_ctrl_pkg.sv | 24 ++
 rtl/hand_deal_ctrl_dup_check.sv | 43 ++++
 rtl/hand_deal_ctrl.sv | 146 ++++++++++++++
 tb/tb_hand_deal_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hand_deal_ctrl_pkg.sv
// Shared card types, rank limits and FSM states
// for the hand dealing controller.
package hand_deal_ctrl_pkg;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  localparam logic [3:0] RANK_MIN = 4'd1;
  localparam logic [3:0] RANK_MAX = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    DEAL,
    WAIT_FULL,
    DONE
  } state_e;

  function automatic logic rank_bad(input card_t c);
    return (c.rank < RANK_MIN) || (c.rank > RANK_MAX);
  endfunction

endpackage

// File: rtl/hand_deal_ctrl_dup_check.sv
// Per-deal card history: registered entries with
// valid bits and a combinational match flag.
module card_dup_check
  import hand_deal_ctrl_pkg::*;
#(
  parameter int N = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       wr_i,
  input  logic [2:0] idx_i,
  input  logic [5:0] card_i,
  output logic       match_o
);

  logic [N-1:0] vld_q;
  logic [5:0]   ent_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
    end else if (clr_i) begin
      vld_q <= '0;
    end else if (wr_i) begin
      vld_q[idx_i] <= 1'b1;
      ent_q[idx_i] <= card_i;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vld_q[i] && (ent_q[i] == card_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hand_deal_ctrl.sv
// Deals HAND_SIZE validated, unique cards into
// the hand memory and waits for its full flag.
module hand_deal_ctrl
  import hand_deal_ctrl_pkg::*;
#(
  parameter int HAND_SIZE    = 5,
  parameter int FULL_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [5:0] in_card,
  output logic       in_ready,
  output logic       mem_we,
  output logic [2:0] mem_waddr,
  output logic [5:0] mem_card,
  input  logic       mem_hand_full,
  output logic       busy,
  output logic [2:0] dealt_count,
  output logic       deal_done,
  output logic       bad_err,
  output logic       dup_err,
  output logic       timeout_err
);

  localparam int TW = $clog2(FULL_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          we_q, we_d;
  logic [2:0]    wa_q, wa_d;
  logic [5:0]    wc_q, wc_d;
  logic          bad_q, bad_d;
  logic          dup_q, dup_d;
  logic          tmo_q, tmo_d;

  logic rdy, acc, bad, hit, wr_ok, clr;

  assign rdy   = (state_q == DEAL)
              && (cnt_q < 4'(HAND_SIZE));
  assign acc   = in_valid && rdy && !abort;
  assign bad   = rank_bad(card_t'(in_card));
  assign wr_ok = acc && !bad && !hit;
  assign clr   = (state_q == IDLE) && start;

  card_dup_check #(
    .N(HAND_SIZE)
  ) u_dup (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .wr_i   (wr_ok),
    .idx_i  (cnt_q[2:0]),
    .card_i (in_card),
    .match_o(hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    we_d    = wr_ok;
    wa_d    = wa_q;
    wc_d    = wc_q;
    bad_d   = acc && bad;
    dup_d   = acc && !bad && hit;
    tmo_d   = 1'b0;
    if (wr_ok) begin
      wa_d  = cnt_q[2:0];
      wc_d  = in_card;
      cnt_d = cnt_q + 4'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DEAL;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      DEAL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wr_ok
            && cnt_q == 4'(HAND_SIZE - 1)) begin
          state_d = WAIT_FULL;
          tmr_d   = '0;
        end
      end
      WAIT_FULL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (mem_hand_full) begin
          state_d = DONE;
        end else if (tmr_q
            == TW'(FULL_TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wc_q    <= '0;
      bad_q   <= 1'b0;
      dup_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wc_q    <= wc_d;
      bad_q   <= bad_d;
      dup_q   <= dup_d;
      tmo_q   <= tmo_d;
    end
  end

  assign in_ready    = rdy;
  assign mem_we      = we_q;
  assign mem_waddr   = wa_q;
  assign mem_card    = wc_q;
  assign busy        = (state_q != IDLE);
  assign dealt_count = cnt_q[2:0];
  assign deal_done   = (state_q == DONE);
  assign bad_err     = bad_q;
  assign dup_err     = dup_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_hand_deal_ctrl.sv
// Bench for hand_deal_ctrl: vector table, corner
// sequences and randomized deals vs a hand model.
module tb_hand_deal_ctrl;

  localparam int HS = 5;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_card = '0;
  logic       mem_hand_full = 1'b0;
  logic       in_ready, mem_we, busy;
  logic [2:0] mem_waddr, dealt_count;
  logic [5:0] mem_card;
  logic       deal_done, bad_err, dup_err;
  logic       timeout_err;

  hand_deal_ctrl #(
    .HAND_SIZE(HS),
    .FULL_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_card      (in_card),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_card     (mem_card),
    .mem_hand_full(mem_hand_full),
    .busy         (busy),
    .dealt_count  (dealt_count),
    .deal_done    (deal_done),
    .bad_err      (bad_err),
    .dup_err      (dup_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [8:0] wr_log [0:4095];
  int wr_n = 0;
  int bad_n = 0;
  int dup_n = 0;
  int done_n = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_log[wr_n] = {mem_waddr, mem_card};
        wr_n = wr_n + 1;
      end
      if (bad_err) bad_n = bad_n + 1;
      if (dup_err) dup_n = dup_n + 1;
      if (deal_done) done_n = done_n + 1;
    end
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [9:0] ov(
    input logic r, w, b, d, ba, du, t,
    input logic [2:0] n);
    return {r, w, b, d, ba, du, t, n};
  endfunction

  function automatic logic [9:0] outs();
    return {in_ready, mem_we, busy, deal_done,
            bad_err, dup_err, timeout_err,
            dealt_count};
  endfunction

  task automatic cyc(input logic s, a, v,
                     input logic [5:0] c,
                     input logic h);
    start = s;
    abort = a;
    in_valid = v;
    in_card = c;
    mem_hand_full = h;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic       ab;
    logic       v;
    logic [5:0] card;
    logic       hf;
    logic [9:0] exp;
    logic [8:0] wr;
  } vec_t;

  vec_t tbl [8];

  logic [5:0] hist [$];
  logic [8:0] expq [$];
  logic [5:0] c;
  logic       v;
  int b_wr, b_bad, b_dup, b_done;
  int eb, ed, guard, n, dly;
  bit seen;

  initial begin
    tbl[0] = '{1, 0, 0, 6'h00, 0,
               ov(1,0,1,0,0,0,0,0), 9'h000};
    tbl[1] = '{0, 0, 1, 6'h01, 0,
               ov(1,1,1,0,0,0,0,1), {3'd0, 6'h01}};
    tbl[2] = '{0, 0, 1, 6'h12, 0,
               ov(1,1,1,0,0,0,0,2), {3'd1, 6'h12}};
    tbl[3] = '{0, 0, 1, 6'h23, 0,
               ov(1,1,1,0,0,0,0,3), {3'd2, 6'h23}};
    tbl[4] = '{0, 0, 1, 6'h3D, 0,
               ov(1,1,1,0,0,0,0,4), {3'd3, 6'h3D}};
    tbl[5] = '{0, 0, 1, 6'h05, 0,
               ov(0,1,1,0,0,0,0,5), {3'd4, 6'h05}};
    tbl[6] = '{0, 0, 0, 6'h00, 1,
               ov(0,0,1,1,0,0,0,5), 9'h000};
    tbl[7] = '{0, 0, 0, 6'h00, 0,
               ov(0,0,0,0,0,0,0,5), 9'h000};

    #12;
    chk("reset_outs", int'(outs()), 0);
    chk("reset_mem", int'({mem_waddr, mem_card}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full deal driven from the vector table
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].v,
          tbl[i].card, tbl[i].hf);
      chk($sformatf("tbl_outs_%0d", i),
          int'(outs()), int'(tbl[i].exp));
      if (tbl[i].exp[8])
        chk($sformatf("tbl_wr_%0d", i),
            int'({mem_waddr, mem_card}),
            int'(tbl[i].wr));
    end

    // invalid ranks mid-deal
    cyc(1, 0, 0, 6'h00, 0);
    cyc(0, 0, 1, 6'h01, 0);
    cyc(0, 0, 1, 6'h00, 0);
    chk("bad0", int'(outs()), int'(ov(1,0,1,0,1,0,0,1)));
    cyc(0, 0, 1, 6'h0E, 0);
    chk("bad14", int'(outs()), int'(ov(1,0,1,0,1,0,0,1)));
    cyc(0, 0, 0, 6'h00, 0);
    chk("bad_clr", int'(outs()), int'(ov(1,0,1,0,0,0,0,1)));
    cyc(0, 1, 0, 6'h00, 0);
    chk("bad_abort", int'(busy), 0);

    // duplicate back-to-back
    cyc(1, 0, 0, 6'h00, 0);
    cyc(0, 0, 1, 6'h21, 0);
    chk("dup_wr", int'({mem_we, mem_waddr, mem_card}),
        int'({1'b1, 3'd0, 6'h21}));
    cyc(0, 0, 1, 6'h21, 0);
    chk("dup_err", int'(outs()), int'(ov(1,0,1,0,0,1,0,1)));
    cyc(0, 0, 0, 6'h00, 0);
    chk("dup_clr", int'(dup_err), 0);
    cyc(0, 1, 0, 6'h00, 0);

    // abort together with a valid card
    b_wr = wr_n;
    b_done = done_n;
    cyc(1, 0, 0, 6'h00, 0);
    cyc(0, 0, 1, 6'h01, 0);
    cyc(0, 0, 1, 6'h02, 0);
    cyc(0, 0, 1, 6'h03, 0);
    cyc(0, 1, 1, 6'h04, 0);
    chk("abort_outs", int'(outs()), int'(ov(0,0,0,0,0,0,0,3)));
    cyc(0, 0, 0, 6'h00, 0);
    chk("abort_nowr", wr_n - b_wr, 3);
    chk("abort_nodone", done_n - b_done, 0);

    // hand_full never arrives
    cyc(1, 0, 0, 6'h00, 0);
    for (int i = 1; i <= HS; i++)
      cyc(0, 0, 1, 6'(i), 0);
    n = 0;
    while (n < 40) begin
      cyc(0, 0, 0, 6'h00, 0);
      n++;
      if (timeout_err) break;
    end
    chk("tmo_cycles", n, TO);
    chk("tmo_idle", int'(busy), 0);
    cyc(0, 0, 0, 6'h00, 0);
    chk("tmo_pulse", int'(timeout_err), 0);

    // asynchronous reset mid-deal
    cyc(1, 0, 0, 6'h00, 0);
    cyc(0, 0, 1, 6'h01, 0);
    cyc(0, 0, 1, 6'h02, 0);
    start = 0;
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", int'(outs()), 0);
    chk("arst_mem", int'({mem_waddr, mem_card}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 6'h00, 0);
    cyc(0, 0, 1, 6'h01, 0);
    chk("arst_rewr", int'({mem_we, mem_waddr, mem_card}),
        int'({1'b1, 3'd0, 6'h01}));
    chk("arst_cnt", int'(dealt_count), 1);
    cyc(0, 1, 0, 6'h00, 0);

    // randomized deals against a hand-level model
    for (int d = 0; d < 20; d++) begin
      b_wr = wr_n;
      b_bad = bad_n;
      b_dup = dup_n;
      b_done = done_n;
      eb = 0;
      ed = 0;
      guard = 0;
      hist.delete();
      expq.delete();
      cyc(1, 0, 0, 6'h00, 0);
      while (hist.size() < HS && guard < 300) begin
        v = ($urandom % 4) != 0;
        if (($urandom % 8) == 0)
          c = {2'($urandom % 4),
               (($urandom % 3) == 0) ? 4'd0
                                     : 4'(14 + $urandom % 2)};
        else
          c = {2'($urandom % 4),
               4'($urandom_range(1, 3))};
        chk("rand_rdy", int'(in_ready), 1);
        if (v && in_ready) begin
          seen = 0;
          foreach (hist[k])
            if (hist[k] == c) seen = 1;
          if (c[3:0] == 0 || c[3:0] > 13)
            eb++;
          else if (seen)
            ed++;
          else begin
            expq.push_back({3'(hist.size()), c});
            hist.push_back(c);
          end
        end
        cyc(0, 0, v, c, 0);
        guard++;
      end
      chk("rand_guard", int'(guard < 300), 1);
      dly = $urandom_range(0, 10);
      repeat (dly) cyc(0, 0, 0, 6'h00, 0);
      cyc(0, 0, 0, 6'h00, 1);
      cyc(0, 0, 0, 6'h00, 0);
      chk("rand_nwr", wr_n - b_wr, expq.size());
      for (int k = 0; k < expq.size(); k++)
        chk($sformatf("rand_wr_%0d", k),
            int'(wr_log[b_wr + k]), int'(expq[k]));
      chk("rand_bad", bad_n - b_bad, eb);
      chk("rand_dup", dup_n - b_dup, ed);
      chk("rand_done", done_n - b_done, 1);
      chk("rand_end", int'({busy, dealt_count}),
          int'({1'b0, 3'(HS)}));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
